rem_slot_scheduler: RTL

//  Slot-level controller for the resource element mapper and its I/Q ping-pong memories.

---
 rtl/rem_slot_scheduler.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rem_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : rem_slot_scheduler
//  Purpose  : Slot-level controller for the resource element mapper and its
//             I/Q ping-pong banks. Latches and validates the per-slot
//             allocation, steps the PUSCH symbols, gates EN_RE once source
//             data is ready and a bank is free, and flags config / timeout
//             errors.
//  Revision : 1.0 - initial release
// ============================================================================
module rem_slot_scheduler #(
    parameter int N_SYM       = 14,
    parameter int FFT_SIZE    = 2048,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        CLK_RE,
    input  logic        RST_RE,
    input  logic        Slot_Start,
    input  logic [10:0] N_sc_In,
    input  logic [6:0]  N_rb_In,
    input  logic [3:0]  Sym_Start_In,
    input  logic [3:0]  Sym_End_In,
    input  logic [13:0] Dmrs_Mask_In,
    input  logic        FFT_Done,
    input  logic        DMRS_Done,
    input  logic        Sym_Done,
    input  logic        Bank_Release,
    output logic        EN_RE,
    output logic [10:0] N_sc,
    output logic [6:0]  N_rb,
    output logic [3:0]  Sym_Start,
    output logic [3:0]  Sym_End,
    output logic [3:0]  Cur_Sym,
    output logic        Is_Dmrs_Sym,
    output logic        Bank_Sel,
    output logic        Busy,
    output logic        Slot_Done,
    output logic        Cfg_Err,
    output logic        Timeout_Err
);

    localparam int          c_tmr_w   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]  c_sym_max = 4'(N_SYM - 1);
    localparam logic [12:0] c_fft_sz  = 13'(FFT_SIZE);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WAIT  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [10:0]        n_sc_q, n_sc_d;
    logic [6:0]         n_rb_q, n_rb_d;
    logic [3:0]         sym_start_q, sym_start_d;
    logic [3:0]         sym_end_q, sym_end_d;
    logic [13:0]        dmrs_mask_q, dmrs_mask_d;
    logic [3:0]         cur_sym_q, cur_sym_d;
    logic               is_dmrs_q, is_dmrs_d;
    logic               bank_sel_q, bank_sel_d;
    logic [1:0]         bank_cnt_q, bank_cnt_d;
    logic               fft_rdy_q, fft_rdy_d;
    logic               dmrs_rdy_q, dmrs_rdy_d;
    logic [c_tmr_w-1:0] timer_q, timer_d;
    logic               en_re_q, en_re_d;
    logic               busy_q, busy_d;
    logic               slot_done_q, slot_done_d;
    logic               cfg_err_q, cfg_err_d;
    logic               timeout_err_q, timeout_err_d;

    logic [12:0]        w_span;
    logic               w_cfg_bad;
    logic               w_src_go;
    logic               w_tmr_exp;
    logic               w_bank_inc;
    logic               w_bank_dec;
    logic [15:0]        w_mask_ext;

    // Allocation span is evaluated at 13 bits so the largest legal inputs cannot wrap.
    assign w_span    = {2'b00, n_sc_q} + (13'(n_rb_q) * 13'd12);
    assign w_cfg_bad = (n_rb_q == 7'd0) || (sym_start_q > sym_end_q) ||
                       (sym_end_q > c_sym_max) || (w_span > c_fft_sz);

    // Same-cycle Done pulses count as ready so no cycle is lost waiting for the flag.
    assign w_src_go  = (fft_rdy_q | FFT_Done) &
                       (~is_dmrs_q | dmrs_rdy_q | DMRS_Done) &
                       (bank_cnt_q < 2'd2);
    assign w_tmr_exp = (timer_q >= c_tmr_last);

    assign w_bank_inc = (state_q == S_RUN) && Sym_Done;
    assign w_bank_dec = Bank_Release && (bank_cnt_q != 2'd0);

    // Next-state, config latch, bank accounting and registered-output computation
    always_comb begin
        state_d       = state_q;
        n_sc_d        = n_sc_q;
        n_rb_d        = n_rb_q;
        sym_start_d   = sym_start_q;
        sym_end_d     = sym_end_q;
        dmrs_mask_d   = dmrs_mask_q;
        cur_sym_d     = cur_sym_q;
        bank_sel_d    = bank_sel_q;
        bank_cnt_d    = bank_cnt_q;
        cfg_err_d     = cfg_err_q;
        timeout_err_d = timeout_err_q;
        fft_rdy_d     = fft_rdy_q  | (FFT_Done  && (state_q != S_IDLE));
        dmrs_rdy_d    = dmrs_rdy_q | (DMRS_Done && (state_q != S_IDLE));

        if (w_bank_inc && !w_bank_dec && (bank_cnt_q < 2'd2)) begin
            bank_cnt_d = bank_cnt_q + 2'd1;
        end else if (w_bank_dec && !w_bank_inc) begin
            bank_cnt_d = bank_cnt_q - 2'd1;
        end

        case (state_q)
            S_IDLE, S_ERR: begin
                if (Slot_Start) begin
                    n_sc_d        = N_sc_In;
                    n_rb_d        = N_rb_In;
                    sym_start_d   = Sym_Start_In;
                    sym_end_d     = Sym_End_In;
                    dmrs_mask_d   = Dmrs_Mask_In;
                    cfg_err_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_cfg_bad) begin
                    cfg_err_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    cur_sym_d = sym_start_q;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_src_go) begin
                    fft_rdy_d  = 1'b0;
                    dmrs_rdy_d = 1'b0;
                    state_d    = S_RUN;
                end else if (w_tmr_exp) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ERR;
                end
            end
            S_RUN: begin
                if (Sym_Done) begin
                    bank_sel_d = ~bank_sel_q;
                    if (cur_sym_q == sym_end_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_sym_d = cur_sym_q + 4'd1;
                        state_d   = S_WAIT;
                    end
                end else if (w_tmr_exp) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timer restarts on every state change and only runs while waiting on sources or the mapper.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == S_WAIT) || (state_q == S_RUN)) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = '0;
        end

        w_mask_ext  = {2'b00, dmrs_mask_d};
        is_dmrs_d   = w_mask_ext[cur_sym_d];
        en_re_d     = (state_d == S_RUN);
        busy_d      = (state_d != S_IDLE) && (state_d != S_ERR);
        slot_done_d = (state_d == S_DONE);
    end

    // State and output registers; reset returns everything to idle at once
    always_ff @(posedge CLK_RE or posedge RST_RE) begin
        if (RST_RE) begin
            state_q       <= S_IDLE;
            n_sc_q        <= '0;
            n_rb_q        <= '0;
            sym_start_q   <= '0;
            sym_end_q     <= '0;
            dmrs_mask_q   <= '0;
            cur_sym_q     <= '0;
            is_dmrs_q     <= 1'b0;
            bank_sel_q    <= 1'b0;
            bank_cnt_q    <= '0;
            fft_rdy_q     <= 1'b0;
            dmrs_rdy_q    <= 1'b0;
            timer_q       <= '0;
            en_re_q       <= 1'b0;
            busy_q        <= 1'b0;
            slot_done_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_sc_q        <= n_sc_d;
            n_rb_q        <= n_rb_d;
            sym_start_q   <= sym_start_d;
            sym_end_q     <= sym_end_d;
            dmrs_mask_q   <= dmrs_mask_d;
            cur_sym_q     <= cur_sym_d;
            is_dmrs_q     <= is_dmrs_d;
            bank_sel_q    <= bank_sel_d;
            bank_cnt_q    <= bank_cnt_d;
            fft_rdy_q     <= fft_rdy_d;
            dmrs_rdy_q    <= dmrs_rdy_d;
            timer_q       <= timer_d;
            en_re_q       <= en_re_d;
            busy_q        <= busy_d;
            slot_done_q   <= slot_done_d;
            cfg_err_q     <= cfg_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign EN_RE       = en_re_q;
    assign N_sc        = n_sc_q;
    assign N_rb        = n_rb_q;
    assign Sym_Start   = sym_start_q;
    assign Sym_End     = sym_end_q;
    assign Cur_Sym     = cur_sym_q;
    assign Is_Dmrs_Sym = is_dmrs_q;
    assign Bank_Sel    = bank_sel_q;
    assign Busy        = busy_q;
    assign Slot_Done   = slot_done_q;
    assign Cfg_Err     = cfg_err_q;
    assign Timeout_Err = timeout_err_q;

endmodule
`default_nettype wire
